// File: rtl/keyer_pkg.sv
// Shared definitions for the iambic keyer: FSM state encoding and element codes.
package keyer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MARK = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic DIT = 1'b0;
    localparam logic DAH = 1'b1;

endpackage

// File: rtl/keyer_input_filter.sv
// 2-FF synchronizer for one contact, followed by a debouncer when
// IAMBIC_KEYER_DEBOUNCE_EN is defined (otherwise the synchronizer output passes straight through).
module keyer_input_filter #(
    parameter int unsigned DEBOUNCE_WIDTH = 16
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic contact,
    output logic level
);

    logic [1:0] sync_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], contact};
        end
    end

`ifdef IAMBIC_KEYER_DEBOUNCE_EN
    logic                      level_q;
    logic [DEBOUNCE_WIDTH-1:0] cnt_q;

    // Flip only after 2^DEBOUNCE_WIDTH consecutive disagreeing cycles.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else if (sync_q[1] == level_q) begin
            cnt_q   <= '0;
        end else if (cnt_q == '1) begin
            level_q <= sync_q[1];
            cnt_q   <= '0;
        end else begin
            cnt_q   <= cnt_q + DEBOUNCE_WIDTH'(1);
        end
    end

    assign level = level_q;
`else
    assign level = sync_q[1];
`endif

endmodule

// File: rtl/iambic_keyer.sv
// Iambic (mode A/B) and straight CW keyer producing key_flag for the envelope keyer.
// Optional input debouncing is compiled in with IAMBIC_KEYER_DEBOUNCE_EN.
module iambic_keyer #(
    parameter int unsigned CNTR_WIDTH     = 32,
    parameter int unsigned DEBOUNCE_WIDTH = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [CNTR_WIDTH-1:0] cfg_data,
    input  logic                  cfg_mode,
    input  logic                  dit_flag,
    input  logic                  dah_flag,
    input  logic                  str_flag,
    output logic                  key_flag
);

    import keyer_pkg::*;

    localparam int unsigned CW = CNTR_WIDTH + 2;

    logic dit, dah, str;

    keyer_input_filter #(.DEBOUNCE_WIDTH(DEBOUNCE_WIDTH)) u_dit (
        .aclk(aclk), .aresetn(aresetn), .contact(dit_flag), .level(dit)
    );
    keyer_input_filter #(.DEBOUNCE_WIDTH(DEBOUNCE_WIDTH)) u_dah (
        .aclk(aclk), .aresetn(aresetn), .contact(dah_flag), .level(dah)
    );
    keyer_input_filter #(.DEBOUNCE_WIDTH(DEBOUNCE_WIDTH)) u_str (
        .aclk(aclk), .aresetn(aresetn), .contact(str_flag), .level(str)
    );

    state_t                state_q, state_d;
    logic                  elem_q, elem_d;
    logic                  mem_q, mem_d;
    logic [CW-1:0]         cntr_q, cntr_d;
    logic [CNTR_WIDTH-1:0] t_reg, t_d;

    logic [CNTR_WIDTH-1:0] t_new;
    logic [CW-1:0]         t_ext;
    logic                  opp, same;
    logic                  start, start_elem;

    assign t_new = (cfg_data == '0) ? CNTR_WIDTH'(1) : cfg_data;
    assign t_ext = {2'b00, t_new};
    assign opp   = (elem_q == DIT) ? dah : dit;
    assign same  = (elem_q == DIT) ? dit : dah;

    always_comb begin
        state_d    = state_q;
        elem_d     = elem_q;
        mem_d      = mem_q;
        cntr_d     = cntr_q;
        t_d        = t_reg;
        start      = 1'b0;
        start_elem = DIT;

        unique case (state_q)
            IDLE: begin
                if (dit) begin
                    start      = 1'b1;
                    start_elem = DIT;
                end else if (dah) begin
                    start      = 1'b1;
                    start_elem = DAH;
                end
            end
            MARK: begin
                mem_d = mem_q | opp;
                if (cntr_q == '0) begin
                    state_d = GAP;
                    cntr_d  = {2'b00, t_reg} - CW'(1);
                end else begin
                    cntr_d  = cntr_q - CW'(1);
                end
            end
            GAP: begin
                mem_d = mem_q | opp;
                if (cntr_q == '0) begin
                    if (opp || (cfg_mode && mem_q)) begin
                        start      = 1'b1;
                        start_elem = ~elem_q;
                    end else if (same) begin
                        start      = 1'b1;
                        start_elem = elem_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cntr_d = cntr_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Every MARK entry (from IDLE or straight out of GAP) relatches T and clears the memory.
        if (start) begin
            state_d = MARK;
            elem_d  = start_elem;
            mem_d   = 1'b0;
            t_d     = t_new;
            cntr_d  = (start_elem == DAH) ? (t_ext + (t_ext << 1)) - CW'(1)
                                          : t_ext - CW'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            elem_q   <= DIT;
            mem_q    <= 1'b0;
            cntr_q   <= '0;
            t_reg    <= '0;
            key_flag <= 1'b0;
        end else begin
            state_q  <= state_d;
            elem_q   <= elem_d;
            mem_q    <= mem_d;
            cntr_q   <= cntr_d;
            t_reg    <= t_d;
            key_flag <= (state_d == MARK) | str;
        end
    end

endmodule

// File: tb/tb_iambic_keyer.sv
// Directed bench for iambic_keyer: T=10, DEBOUNCE_WIDTH=4; the debounce cases are
// selected when IAMBIC_KEYER_DEBOUNCE_EN is defined.
`timescale 1ns/1ps
module tb_iambic_keyer;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] cfg_data;
    logic        cfg_mode;
    logic        dit_flag, dah_flag, str_flag;
    logic        key_flag;

    int checks = 0;
    int errors = 0;

    logic trace [0:399];
    int   st    [0:399];

    always #5 aclk = ~aclk;

    iambic_keyer #(.CNTR_WIDTH(32), .DEBOUNCE_WIDTH(4)) dut (
        .aclk(aclk), .aresetn(aresetn), .cfg_data(cfg_data), .cfg_mode(cfg_mode),
        .dit_flag(dit_flag), .dah_flag(dah_flag), .str_flag(str_flag), .key_flag(key_flag)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Cycle i drives inputs before edge i, then records key_flag and state 1 ns after it.
    task automatic run(input int n, input int d0, input int d1, input int a0, input int a1,
                       input int s0, input int s1, input int r0, input int r1);
        for (int i = 0; i < n; i++) begin
            dit_flag = (i >= d0 && i < d1);
            dah_flag = (i >= a0 && i < a1);
            str_flag = (i >= s0 && i < s1);
            aresetn  = !(i >= r0 && i < r1);
            @(posedge aclk);
            #1;
            trace[i] = key_flag;
            st[i]    = int'(dut.state_q);
        end
        dit_flag = 1'b0;
        dah_flag = 1'b0;
        str_flag = 1'b0;
        aresetn  = 1'b1;
    endtask

    function automatic int run_len(input int start, input int n);
        int k;
        k = start;
        while (k < n && trace[k] === trace[start]) k++;
        return k - start;
    endfunction

    function automatic int highs(input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) if (trace[i] === 1'b1) c++;
        return c;
    endfunction

    task automatic flush();
        run(40, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        cfg_data = 32'd10;
        cfg_mode = 1'b0;
        dit_flag = 1'b0;
        dah_flag = 1'b0;
        str_flag = 1'b0;
        aresetn  = 1'b0;

        run(3, 0, 0, 0, 0, 0, 0, 0, 3);
        check_val("reset_key", int'(trace[2]), 0);
        check_val("reset_state", st[2], 0);
        flush();

`ifndef IAMBIC_KEYER_DEBOUNCE_EN
        // Dit tap
        run(40, 0, 5, 0, 0, 0, 0, 0, 0);
        check_val("dit_pre", int'(trace[1]), 0);
        check_val("dit_rise", int'(trace[2]), 1);
        check_val("dit_len", run_len(2, 40), 10);
        check_val("dit_gap_state", st[21], 2);
        check_val("dit_idle_state", st[22], 0);
        check_val("dit_highs", highs(40), 10);
        flush();

        // Dah held, released during the fifth mark
        run(260, 0, 0, 0, 180, 0, 0, 0, 0);
        check_val("dah_len0", run_len(2, 260), 30);
        check_val("dah_gap0", run_len(32, 260), 10);
        check_val("dah_len1", run_len(42, 260), 30);
        check_val("dah_last", run_len(162, 260), 30);
        check_val("dah_after", int'(trace[202]), 0);
        check_val("dah_idle", st[202], 0);
        check_val("dah_highs", highs(260), 150);
        flush();

        // Squeeze, mode A
        run(160, 0, 100, 0, 100, 0, 0, 0, 0);
        check_val("sq_dit0", run_len(2, 160), 10);
        check_val("sq_gap0", run_len(12, 160), 10);
        check_val("sq_dah0", run_len(22, 160), 30);
        check_val("sq_dit1", run_len(62, 160), 10);
        check_val("sq_dah1", run_len(82, 160), 30);
        check_val("sq_idle", st[122], 0);
        check_val("sq_highs", highs(160), 80);
        flush();

        // Mode B memory
        cfg_mode = 1'b1;
        run(100, 0, 5, 4, 7, 0, 0, 0, 0);
        check_val("mb_dit", run_len(2, 100), 10);
        check_val("mb_gap", run_len(12, 100), 10);
        check_val("mb_dah", run_len(22, 100), 30);
        check_val("mb_idle", st[62], 0);
        check_val("mb_highs", highs(100), 40);
        flush();

        // Same stimulus, mode A
        cfg_mode = 1'b0;
        run(100, 0, 5, 4, 7, 0, 0, 0, 0);
        check_val("ma_dit", run_len(2, 100), 10);
        check_val("ma_idle", st[22], 0);
        check_val("ma_highs", highs(100), 10);
        flush();

        // Straight key
        run(30, 0, 0, 0, 0, 0, 7, 0, 0);
        check_val("str_pre", int'(trace[1]), 0);
        check_val("str_len", run_len(2, 30), 7);
        check_val("str_fsm", st[4], 0);
        check_val("str_highs", highs(30), 7);
        flush();

        // cfg_data = 0 behaves as T = 1
        cfg_data = 32'd0;
        run(20, 0, 1, 0, 0, 0, 0, 0, 0);
        check_val("t0_rise", int'(trace[2]), 1);
        check_val("t0_len", run_len(2, 20), 1);
        check_val("t0_idle", st[4], 0);
        check_val("t0_highs", highs(20), 1);
        cfg_data = 32'd10;
        flush();

        // Reset mid-dah
        run(40, 0, 0, 0, 12, 0, 0, 12, 14);
        check_val("rst_before", int'(trace[11]), 1);
        check_val("rst_key", int'(trace[12]), 0);
        check_val("rst_state", st[13], 0);
        check_val("rst_after", st[20], 0);
        check_val("rst_highs", highs(40), 10);
`else
        // 10-cycle glitch is filtered out
        run(60, 0, 10, 0, 0, 0, 0, 0, 0);
        check_val("db_glitch", highs(60), 0);
        flush();

        // 20-cycle press: mark 16 cycles later than undebounced
        run(80, 0, 20, 0, 0, 0, 0, 0, 0);
        check_val("db_pre", int'(trace[17]), 0);
        check_val("db_rise", int'(trace[18]), 1);
        check_val("db_len", run_len(18, 80), 10);
        check_val("db_idle", st[38], 0);
        check_val("db_highs", highs(80), 10);
        flush();

        // Debounced straight key
        run(60, 0, 0, 0, 0, 0, 20, 0, 0);
        check_val("db_str_pre", int'(trace[17]), 0);
        check_val("db_str_len", run_len(18, 60), 20);
        flush();

        // Reset mid-dah
        run(60, 0, 0, 0, 25, 0, 0, 25, 27);
        check_val("db_rst_before", int'(trace[24]), 1);
        check_val("db_rst_key", int'(trace[25]), 0);
        check_val("db_rst_state", st[26], 0);
        check_val("db_rst_highs", highs(60), 7);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
